// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with multi-cycle MULT/DIV sequencing.
// Uses a valid/ready handshake and drives busy/stall to the datapath and start to the mul/div unit.
module alu_ctrl_seq #(
   parameter int FUNCT_W    = 6,
   parameter int ALUOP_W    = 3,
   parameter int CTRL_W     = 4,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic               flush_i,
   output logic               ready_o,
   output logic [CTRL_W-1:0]  ALUCtrl_o,
   output logic               ctrl_valid_o,
   output logic               start_o,
   output logic               busy_o,
   output logic               stall_o,
   output logic               illegal_o
);

   localparam int CNT_W = 8;

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic [3:0]       code;
      logic             multi;
      logic             illegal;
      logic [CNT_W-1:0] len;
   } dec_t;

   function automatic dec_t decode(input logic [ALUOP_W-1:0] op,
                                   input logic [FUNCT_W-1:0] fn);
      dec_t d;
      d = '{code: 4'b1111, multi: 1'b0, illegal: 1'b1, len: '0};
      case (op)
         ALUOP_W'(0): begin
            d.illegal = 1'b0;
            case (fn)
               FUNCT_W'(6'b100100): d.code = 4'b0000;
               FUNCT_W'(6'b100000): d.code = 4'b0010;
               FUNCT_W'(6'b100010): d.code = 4'b0110;
               FUNCT_W'(6'b100101): d.code = 4'b0001;
               FUNCT_W'(6'b101010): d.code = 4'b0111;
               FUNCT_W'(6'b100111): d.code = 4'b1100;
               FUNCT_W'(6'b000000): d.code = 4'b1000;
               FUNCT_W'(6'b000010): d.code = 4'b1001;
               FUNCT_W'(6'b011000): begin
                  d.code  = 4'b1010;
                  d.multi = 1'b1;
                  d.len   = CNT_W'(MUL_CYCLES - 1);
               end
               FUNCT_W'(6'b011010): begin
                  d.code  = 4'b1011;
                  d.multi = 1'b1;
                  d.len   = CNT_W'(DIV_CYCLES - 1);
               end
               default: d.illegal = 1'b1;
            endcase
         end
         ALUOP_W'(1): begin d.code = 4'b0010; d.illegal = 1'b0; end
         ALUOP_W'(2): begin d.code = 4'b0111; d.illegal = 1'b0; end
         ALUOP_W'(3): begin d.code = 4'b0010; d.illegal = 1'b0; end
         ALUOP_W'(4): begin d.code = 4'b0010; d.illegal = 1'b0; end
         ALUOP_W'(5): begin d.code = 4'b0110; d.illegal = 1'b0; end
         ALUOP_W'(6): begin d.code = 4'b0001; d.illegal = 1'b0; end
         default: ;
      endcase
      return d;
   endfunction

   // The "no operation" code 1111 widens to all-ones; every other code zero-extends.
   function automatic logic [CTRL_W-1:0] widen(input logic [3:0] code);
      return (code == 4'b1111) ? {CTRL_W{1'b1}} : CTRL_W'(code);
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
   logic               cv_q, cv_d;
   logic               start_q, start_d;
   logic               ill_q, ill_d;
   logic               accept;
   dec_t               dec;

   assign ready_o = (state_q == IDLE) || (state_q == BUSY && cnt_q == '0);
   assign accept  = valid_i && ready_o && !flush_i;
   assign dec     = decode(ALUOp_i, funct_i);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      cv_d    = 1'b0;
      start_d = 1'b0;
      ill_d   = 1'b0;

      if (state_q == BUSY) begin
         if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
         else             state_d = IDLE;
      end

      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         ctrl_d = widen(dec.code);
         if (dec.multi) begin
            state_d = BUSY;
            cnt_d   = dec.len;
            start_d = 1'b1;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            cv_d    = 1'b1;
            ill_d   = dec.illegal;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctrl_q  <= {CTRL_W{1'b1}};
         cv_q    <= 1'b0;
         start_q <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         cv_q    <= cv_d;
         start_q <= start_d;
         ill_q   <= ill_d;
      end
   end

   // Multi-cycle completion is signalled in the last BUSY cycle, when the counter has run out.
   assign busy_o       = (state_q == BUSY);
   assign stall_o      = busy_o && (cnt_q != '0);
   assign ctrl_valid_o = cv_q || (busy_o && cnt_q == '0);
   assign start_o      = start_q;
   assign illegal_o    = ill_q;
   assign ALUCtrl_o    = ctrl_q;

endmodule
